// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART: FSM states, data-width codes, oversample default.
// Pure declarations; no latency or backpressure of its own.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [1:0] DBITS_5 = 2'd0;
    localparam logic [1:0] DBITS_6 = 2'd1;
    localparam logic [1:0] DBITS_7 = 2'd2;
    localparam logic [1:0] DBITS_8 = 2'd3;

    localparam int OVS_DEFAULT = 16;

    // Index of the final data bit for a given data_bits code.
    function automatic logic [2:0] last_data_idx(input logic [1:0] code);
        case (code)
            DBITS_5: return 3'd4;
            DBITS_6: return 3'd5;
            DBITS_7: return 3'd6;
            default: return 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock tick every div+1 clocks while enabled, zero latency.
// No backpressure; counter is held at 0 when disabled and restarts synchronously on restart.
module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             restart,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    assign tick = en && (cnt == div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || !en) begin
            cnt <= '0;
        end else if (cnt == div) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver (5-8 data bits, parity, 1/2 stop); valid one clock after final stop decision.
// No backpressure: each word is presented as a single-cycle valid pulse and held until the next one.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int OVS         = OVS_DEFAULT,
    parameter int DIV_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] div,
    input  logic [1:0]       data_bits,
    input  logic             parity_en,
    input  logic             parity_odd,
    input  logic             stop2,
    input  logic             rx,
    output logic [7:0]       data_o,
    output logic             valid,
    output logic             parity_err,
    output logic             frame_err,
    output logic             busy
);

    localparam int            SW     = $clog2(OVS);
    localparam logic [SW-1:0] S_A    = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] S_B    = SW'(OVS / 2);
    localparam logic [SW-1:0] S_C    = SW'(OVS / 2 + 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVS - 1);

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   rx_prev;
    logic                   fall;

    logic [DIV_W-1:0] div_q;
    logic [1:0]       dbits_q;
    logic             par_en_q;
    logic             par_odd_q;
    logic             stop2_q;

    logic             baud_en;
    logic             tick;
    logic             start_edge;
    logic             done;
    logic             at_a, at_b, at_dec, at_last;
    logic             maj;

    logic [SW-1:0]    s_cnt;
    logic [2:0]       bit_idx;
    logic [2:0]       last_idx;
    logic [7:0]       shreg;
    logic             samp_a, samp_b;
    logic             par_acc;
    logic             perr_pend;
    logic             ferr_pend;
    logic             stop_second;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '1;
            rx_prev <= 1'b1;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], rx};
            rx_prev <= rx_s;
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];
    assign fall = rx_prev & ~rx_s;

    assign baud_en = (state != IDLE);

    uart_baud_tick #(
        .DIV_W(DIV_W)
    ) u_baud_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (baud_en),
        .restart (start_edge),
        .div     (div_q),
        .tick    (tick)
    );

    assign at_a     = tick && (s_cnt == S_A);
    assign at_b     = tick && (s_cnt == S_B);
    assign at_dec   = tick && (s_cnt == S_C);
    assign at_last  = tick && (s_cnt == S_LAST);
    // Third sample is the live synced value at the decision tick.
    assign maj      = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
    assign last_idx = last_data_idx(dbits_q);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        start_edge = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    state_nxt  = START;
                    start_edge = 1'b1;
                end
            end
            START: begin
                if (at_dec && maj) begin
                    state_nxt = IDLE;
                end else if (at_last) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (at_last && (bit_idx == last_idx)) begin
                    state_nxt = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (at_last) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                // Leave at the final stop decision so a new start edge can follow immediately.
                if (at_dec && (!stop2_q || stop_second)) begin
                    state_nxt = IDLE;
                    done      = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q       <= '0;
            dbits_q     <= DBITS_8;
            par_en_q    <= 1'b0;
            par_odd_q   <= 1'b0;
            stop2_q     <= 1'b0;
            s_cnt       <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            samp_a      <= 1'b1;
            samp_b      <= 1'b1;
            par_acc     <= 1'b0;
            perr_pend   <= 1'b0;
            ferr_pend   <= 1'b0;
            stop_second <= 1'b0;
            data_o      <= '0;
            valid       <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            valid <= done;
            if (start_edge) begin
                div_q       <= div;
                dbits_q     <= data_bits;
                par_en_q    <= parity_en;
                par_odd_q   <= parity_odd;
                stop2_q     <= stop2;
                s_cnt       <= '0;
                bit_idx     <= '0;
                shreg       <= '0;
                par_acc     <= 1'b0;
                perr_pend   <= 1'b0;
                ferr_pend   <= 1'b0;
                stop_second <= 1'b0;
            end else if (state == IDLE) begin
                s_cnt <= '0;
            end else if (tick) begin
                s_cnt <= at_last ? '0 : s_cnt + 1'b1;
                if (at_a) begin
                    samp_a <= rx_s;
                end
                if (at_b) begin
                    samp_b <= rx_s;
                end
                if (at_dec) begin
                    case (state)
                        DATA: begin
                            shreg[bit_idx] <= maj;
                            par_acc        <= par_acc ^ maj;
                        end
                        PARITY: begin
                            if (maj != (par_acc ^ par_odd_q)) begin
                                perr_pend <= 1'b1;
                            end
                        end
                        STOP: begin
                            if (!maj) begin
                                ferr_pend <= 1'b1;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
                if (at_last) begin
                    if (state == DATA) begin
                        bit_idx <= bit_idx + 1'b1;
                    end
                    if (state == STOP) begin
                        stop_second <= 1'b1;
                    end
                end
            end
            if (done) begin
                data_o     <= shreg;
                parity_err <= par_en_q & perr_pend;
                frame_err  <= ferr_pend | ~maj;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: serial frames built from bit lists, decoded by a reference model.
module tb_uart_rx_cfg;

    localparam int OVS         = 16;
    localparam int DIV_W       = 16;
    localparam int SYNC_STAGES = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [DIV_W-1:0] div = '0;
    logic [1:0]       data_bits = 2'd3;
    logic             parity_en = 1'b0;
    logic             parity_odd = 1'b0;
    logic             stop2 = 1'b0;
    logic             rx = 1'b1;
    logic [7:0]       data_o;
    logic             valid;
    logic             parity_err;
    logic             frame_err;
    logic             busy;

    uart_rx_cfg #(
        .OVS         (OVS),
        .DIV_W       (DIV_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .div        (div),
        .data_bits  (data_bits),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .stop2      (stop2),
        .rx         (rx),
        .data_o     (data_o),
        .valid      (valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int dbl = 0;
    logic valid_last = 1'b0;

    logic [7:0] obs_d[$];
    bit         obs_p[$];
    bit         obs_f[$];
    int         obs_c[$];
    logic [7:0] exp_d[$];
    bit         exp_p[$];
    bit         exp_f[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n && valid === 1'b1) begin
            obs_d.push_back(data_o);
            obs_p.push_back(parity_err);
            obs_f.push_back(frame_err);
            obs_c.push_back(cyc);
            if (valid_last === 1'b1) dbl++;
        end
        valid_last = valid;
    end

    task automatic drive_bit(input logic b, input int p, input bit spike);
        for (int c = 0; c < p; c++) begin
            rx = (spike && c == p / 2) ? ~b : b;
            @(posedge clk);
            #1;
        end
        rx = b;
    endtask

    // Builds the serial bit list, predicts the decoded word from it, then drives it.
    task automatic send_frame(input logic [7:0] d, input int nb, input bit pe, input bit po,
                              input bit s2, input bit flip, input bit [1:0] sl, input int dv,
                              input bit spike, input bit scramble, input int gap);
        bit         bits[12];
        int         len;
        int         nstop;
        int         p;
        logic [7:0] ed;
        bit         ep;
        bit         ef;
        p          = (dv + 1) * OVS;
        div        = DIV_W'(dv);
        data_bits  = 2'(nb - 5);
        parity_en  = pe;
        parity_odd = po;
        stop2      = s2;
        bits[0] = 1'b0;
        for (int i = 0; i < nb; i++) bits[1 + i] = d[i];
        len = 1 + nb;
        if (pe) begin
            bit x;
            x = po ^ flip;
            for (int i = 0; i < nb; i++) x ^= d[i];
            bits[len] = x;
            len++;
        end
        bits[len] = ~sl[0];
        len++;
        nstop = 1;
        if (s2) begin
            bits[len] = ~sl[1];
            len++;
            nstop = 2;
        end
        ed = 8'h00;
        for (int i = 0; i < nb; i++) ed[i] = bits[1 + i];
        ep = pe && (bits[1 + nb] != ((^ed) ^ po));
        ef = 1'b0;
        for (int i = len - nstop; i < len; i++) if (!bits[i]) ef = 1'b1;
        exp_d.push_back(ed);
        exp_p.push_back(ep);
        exp_f.push_back(ef);
        for (int i = 0; i < len; i++) begin
            drive_bit(bits[i], p, spike && (i < len - nstop));
            if (scramble && i == 0) begin
                div        = DIV_W'($urandom);
                data_bits  = 2'($urandom);
                parity_en  = 1'($urandom);
                parity_odd = 1'($urandom);
                stop2      = 1'($urandom);
            end
        end
        rx = 1'b1;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        n_cmp++; if (data_o !== 8'h00) begin n_bad++; $display("FAIL reset_data_o: got %h want 00", data_o); end
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid); end
        n_cmp++; if (parity_err !== 1'b0) begin n_bad++; $display("FAIL reset_parity_err: got %b want 0", parity_err); end
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_8n1;
        int c0;
        logic [7:0] od;
        c0 = cyc;
        send_frame(8'hA5, 8, 0, 0, 0, 0, 2'b00, 0, 0, 0, 20);
        n_cmp++;
        if (obs_d.size() != 1) begin
            n_bad++; $display("FAIL 8n1_count: got %0d want 1", obs_d.size());
        end else begin
            od = obs_d.pop_front();
            n_cmp++; if (od !== 8'hA5) begin n_bad++; $display("FAIL 8n1_data: got %h want a5", od); end
            n_cmp++; if (obs_p.pop_front() !== 1'b0) begin n_bad++; $display("FAIL 8n1_perr: got 1 want 0"); end
            n_cmp++; if (obs_f.pop_front() !== 1'b0) begin n_bad++; $display("FAIL 8n1_ferr: got 1 want 0"); end
            c0 = obs_c.pop_front() - c0;
            n_cmp++; if (c0 < 148 || c0 > 166) begin n_bad++; $display("FAIL 8n1_latency: got %0d want 148..166", c0); end
        end
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL 8n1_valid_low: got %b want 0", valid); end
        obs_d.delete(); obs_p.delete(); obs_f.delete(); obs_c.delete();
        exp_d.delete(); exp_p.delete(); exp_f.delete();
    endtask

    task automatic test_parity;
        logic [7:0] od, ed;
        bit op, ep, of, ef;
        send_frame(8'h41, 7, 1, 0, 0, 0, 2'b00, 0, 0, 0, 20);
        send_frame(8'h41, 7, 1, 0, 0, 1, 2'b00, 0, 0, 0, 20);
        n_cmp++; if (obs_d.size() != 2) begin n_bad++; $display("FAIL parity_count: got %0d want 2", obs_d.size()); end
        while (obs_d.size() > 0 && exp_d.size() > 0) begin
            od = obs_d.pop_front(); ed = exp_d.pop_front();
            op = obs_p.pop_front(); ep = exp_p.pop_front();
            of = obs_f.pop_front(); ef = exp_f.pop_front();
            n_cmp++; if (od !== ed) begin n_bad++; $display("FAIL parity_data: got %h want %h", od, ed); end
            n_cmp++; if (op !== ep) begin n_bad++; $display("FAIL parity_perr: got %b want %b", op, ep); end
            n_cmp++; if (of !== ef) begin n_bad++; $display("FAIL parity_ferr: got %b want %b", of, ef); end
        end
        obs_d.delete(); obs_p.delete(); obs_f.delete(); obs_c.delete();
        exp_d.delete(); exp_p.delete(); exp_f.delete();
    endtask

    task automatic test_5o2_frame_err;
        logic [7:0] od;
        send_frame(8'h1F, 5, 1, 1, 1, 0, 2'b10, 0, 0, 0, 20);
        n_cmp++;
        if (obs_d.size() != 1) begin
            n_bad++; $display("FAIL 5o2_count: got %0d want 1", obs_d.size());
        end else begin
            od = obs_d.pop_front();
            n_cmp++; if (od !== 8'h1F) begin n_bad++; $display("FAIL 5o2_data: got %h want 1f", od); end
            n_cmp++; if (obs_p.pop_front() !== 1'b0) begin n_bad++; $display("FAIL 5o2_perr: got 1 want 0"); end
            n_cmp++; if (obs_f.pop_front() !== 1'b1) begin n_bad++; $display("FAIL 5o2_ferr: got 0 want 1"); end
        end
        obs_d.delete(); obs_p.delete(); obs_f.delete(); obs_c.delete();
        exp_d.delete(); exp_p.delete(); exp_f.delete();
    endtask

    task automatic test_glitch;
        div = '0;
        rx = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rx = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL glitch_busy_start: got %b want 1", busy); end
        repeat (30) begin @(posedge clk); #1; end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL glitch_busy_end: got %b want 0", busy); end
        n_cmp++; if (obs_d.size() != 0) begin n_bad++; $display("FAIL glitch_count: got %0d want 0", obs_d.size()); end
        n_cmp++; if (data_o !== 8'h1F || frame_err !== 1'b1) begin
            n_bad++; $display("FAIL glitch_hold: got %h/%b want 1f/1", data_o, frame_err);
        end
        obs_d.delete(); obs_p.delete(); obs_f.delete(); obs_c.delete();
    endtask

    task automatic test_back_to_back;
        logic [7:0] od, ed;
        bit op, ep, of, ef;
        send_frame(8'h00, 8, 0, 0, 0, 0, 2'b00, 0, 1, 0, 0);
        send_frame(8'hFF, 8, 0, 0, 0, 0, 2'b00, 0, 1, 0, 20);
        n_cmp++; if (obs_d.size() != 2) begin n_bad++; $display("FAIL b2b_count: got %0d want 2", obs_d.size()); end
        while (obs_d.size() > 0 && exp_d.size() > 0) begin
            od = obs_d.pop_front(); ed = exp_d.pop_front();
            op = obs_p.pop_front(); ep = exp_p.pop_front();
            of = obs_f.pop_front(); ef = exp_f.pop_front();
            n_cmp++; if (od !== ed) begin n_bad++; $display("FAIL b2b_data: got %h want %h", od, ed); end
            n_cmp++; if (op !== ep || of !== ef) begin
                n_bad++; $display("FAIL b2b_flags: got %b%b want %b%b", op, of, ep, ef);
            end
        end
        obs_d.delete(); obs_p.delete(); obs_f.delete(); obs_c.delete();
        exp_d.delete(); exp_p.delete(); exp_f.delete();
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] od;
        div = '0; data_bits = 2'd3; parity_en = 1'b0; stop2 = 1'b0;
        drive_bit(1'b0, OVS, 0);
        drive_bit(1'b0, OVS, 0);
        drive_bit(1'b0, OVS, 0);
        drive_bit(1'b1, OVS, 0);
        drive_bit(1'b1, OVS, 0);
        rx = 1'b1;
        repeat (8) begin @(posedge clk); #1; end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy_before: got %b want 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (data_o !== 8'h00 || valid !== 1'b0 || parity_err !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_outputs: got %h/%b/%b/%b/%b want 00/0/0/0/0",
                              data_o, valid, parity_err, frame_err, busy);
        end
        repeat (5) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        n_cmp++; if (obs_d.size() != 0) begin n_bad++; $display("FAIL rstmid_novalid: got %0d want 0", obs_d.size()); end
        obs_d.delete(); obs_p.delete(); obs_f.delete(); obs_c.delete();
        send_frame(8'h81, 8, 0, 0, 0, 0, 2'b00, 0, 0, 0, 20);
        n_cmp++;
        if (obs_d.size() != 1) begin
            n_bad++; $display("FAIL rstmid_next_count: got %0d want 1", obs_d.size());
        end else begin
            od = obs_d.pop_front();
            n_cmp++; if (od !== 8'h81) begin n_bad++; $display("FAIL rstmid_next_data: got %h want 81", od); end
        end
        obs_d.delete(); obs_p.delete(); obs_f.delete(); obs_c.delete();
        exp_d.delete(); exp_p.delete(); exp_f.delete();
    endtask

    task automatic test_break;
        logic [7:0] od, ed;
        bit op, ep, of, ef;
        div = '0; data_bits = 2'd3; parity_en = 1'b0; stop2 = 1'b0;
        rx = 1'b0;
        repeat (OVS * 30) begin @(posedge clk); #1; end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL break_rearm_busy: got %b want 0", busy); end
        exp_d.push_back(8'h00); exp_p.push_back(1'b0); exp_f.push_back(1'b1);
        rx = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        send_frame(8'h5A, 8, 0, 0, 0, 0, 2'b00, 0, 0, 0, 20);
        n_cmp++; if (obs_d.size() != 2) begin n_bad++; $display("FAIL break_count: got %0d want 2", obs_d.size()); end
        while (obs_d.size() > 0 && exp_d.size() > 0) begin
            od = obs_d.pop_front(); ed = exp_d.pop_front();
            op = obs_p.pop_front(); ep = exp_p.pop_front();
            of = obs_f.pop_front(); ef = exp_f.pop_front();
            n_cmp++; if (od !== ed) begin n_bad++; $display("FAIL break_data: got %h want %h", od, ed); end
            n_cmp++; if (op !== ep || of !== ef) begin
                n_bad++; $display("FAIL break_flags: got %b%b want %b%b", op, of, ep, ef);
            end
        end
        obs_d.delete(); obs_p.delete(); obs_f.delete(); obs_c.delete();
        exp_d.delete(); exp_p.delete(); exp_f.delete();
    endtask

    task automatic test_random;
        logic [7:0] od, ed;
        bit op, ep, of, ef;
        int nf;
        nf = 16;
        for (int k = 0; k < nf; k++) begin
            bit pe;
            pe = 1'($urandom);
            send_frame(8'($urandom), 5 + int'($urandom_range(0, 3)), pe, 1'($urandom), 1'($urandom),
                       pe & ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3) == 0 ? $urandom : 0),
                       int'($urandom_range(0, 3)), 0, 1, int'($urandom_range(4, 20)));
        end
        n_cmp++; if (obs_d.size() != nf) begin n_bad++; $display("FAIL random_count: got %0d want %0d", obs_d.size(), nf); end
        while (obs_d.size() > 0 && exp_d.size() > 0) begin
            od = obs_d.pop_front(); ed = exp_d.pop_front();
            op = obs_p.pop_front(); ep = exp_p.pop_front();
            of = obs_f.pop_front(); ef = exp_f.pop_front();
            n_cmp++; if (od !== ed) begin n_bad++; $display("FAIL random_data: got %h want %h", od, ed); end
            n_cmp++; if (op !== ep) begin n_bad++; $display("FAIL random_perr: got %b want %b (data %h)", op, ep, ed); end
            n_cmp++; if (of !== ef) begin n_bad++; $display("FAIL random_ferr: got %b want %b (data %h)", of, ef, ed); end
        end
        n_cmp++; if (dbl != 0) begin n_bad++; $display("FAIL valid_width: got %0d multi-cycle pulses want 0", dbl); end
        obs_d.delete(); obs_p.delete(); obs_f.delete(); obs_c.delete();
        exp_d.delete(); exp_p.delete(); exp_f.delete();
    endtask

    initial begin
        rx = 1'b1;
        rst_n = 1'b0;
        #2;
        test_reset();
        #20;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        test_8n1();
        test_parity();
        test_5o2_frame_err();
        test_glitch();
        test_back_to_back();
        test_reset_mid_frame();
        test_break();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
